key_debounce_array: RTL



---
 rtl/key_debounce_array.sv | 130 +++++++++++++
 1 files changed

// File: rtl/key_debounce_array.sv
// key_debounce_array: multi-channel key debouncer with tick-sampled
// stability filter, press/release edge pulses and long-press detection.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   key         raw asynchronous key inputs, one bit per channel
//   key_level   debounced level, 1 = pressed
//   key_press   1-cycle pulse when key_level goes 0->1
//   key_release 1-cycle pulse when key_level goes 1->0
//   key_long    1-cycle pulse once per hold at LONG_TICKS ticks
module key_debounce_array #(
    parameter int CHANNELS     = 4,
    parameter int SAMPLE_DIV   = 50000,
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 100,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] key,
    output logic [CHANNELS-1:0] key_level,
    output logic [CHANNELS-1:0] key_press,
    output logic [CHANNELS-1:0] key_release,
    output logic [CHANNELS-1:0] key_long
);

    localparam int TICK_W = $clog2(SAMPLE_DIV);
    localparam int STAB_W = $clog2(STABLE_TICKS) + 1;
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] sample;

    // Shared sample-tick generator
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Two-flop synchroniser on the raw keys
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    // Normalise polarity so that 1 always means pressed
    assign sample = sync2 ^ {CHANNELS{ACTIVE_LOW}};

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [STAB_W-1:0] stab_cnt;
        logic [HOLD_W-1:0] hold_cnt;
        logic              level_q;
        logic              press_q;
        logic              release_q;
        logic              long_q;
        logic              flip;

        // Level flips on the tick that completes the run of
        // STABLE_TICKS consecutive samples differing from it
        assign flip = tick
                   && (sample[i] != level_q)
                   && (stab_cnt == STAB_LAST);

        always_ff @(posedge clk) begin
            if (rst) begin
                stab_cnt  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                // Edge pulses land in the same cycle as the new level
                press_q   <= flip && sample[i];
                release_q <= flip && !sample[i];
                if (tick) begin
                    if ((sample[i] == level_q) || flip) begin
                        stab_cnt <= '0;
                    end else begin
                        stab_cnt <= stab_cnt + STAB_W'(1);
                    end
                end
                if (flip) begin
                    level_q <= sample[i];
                end
            end
        end

        // Hold counter saturates, so key_long fires once per hold
        always_ff @(posedge clk) begin
            if (rst) begin
                hold_cnt <= '0;
                long_q   <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (!level_q) begin
                    hold_cnt <= '0;
                end else if (tick && (hold_cnt != HOLD_MAX)) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                    long_q   <= (hold_cnt == HOLD_LAST);
                end
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_long[i]    = long_q;
    end

endmodule
